arm_muldiv_unit: RTL and testbench
==================================

Name: arm_muldiv_unit

Overview:
Parametrised iterative multiply/divide execution unit that sits beside the ALU in the EX stage of the pipelined ARM core. It handles MUL, UMULL, SMULL, UDIV and SDIV, all of which the single-cycle ALU lacks. It uses a start/busy/done handshake so the hazard logic can stall the pipeline while an operation runs. A flush input cancels an in-flight operation on a branch taken or exception.

Parameters:
WIDTH, 32, operand width in bits; results are WIDTH (lo) and WIDTH (hi); must be ≥4 and even
CNT_W, $clog2(WIDTH), width of the iteration counter (derived, not overridden)

Ports:
clk  input  1  single clock, all state updates on posedge
reset  input  1  synchronous, active-high; sampled on posedge clk
start  input  1  request; sampled only when the unit is not busy
op  input  3  000 MUL, 001 UMULL, 010 SMULL, 011 UDIV, 100 SDIV, 101-111 reserved
a  input  WIDTH  multiplicand / dividend (Rn)
b  input  WIDTH  multiplier / divisor (Rm)
flush  input  1  cancel the in-flight operation
busy  output  1  high while an operation is in progress (stall request)
done  output  1  one-cycle pulse; results valid from this cycle on
result_lo  output  WIDTH  product[WIDTH-1:0] or quotient
result_hi  output  WIDTH  product[2*WIDTH-1:WIDTH] (long), 0 (MUL), or remainder
flags  output  2  {N,Z} of the result, valid with done

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset puts the unit in IDLE and clears busy, done, result_lo, result_hi and flags to 0.
- Priority on each edge: reset > flush > start.
- Accepting a request:
  - In IDLE or DONE, start=1 with a valid op latches a, b and op, records the sign of each operand (signed ops only), stores magnitudes, loads the counter with WIDTH-1 and moves to CALC.
  - start with a reserved op is ignored.
  - start in CALC or FIX is ignored; it is not queued.
- CALC: one radix-2 step per cycle for WIDTH cycles; the counter decrements and the state leaves CALC when the counter reaches 0.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
- FIX: one cycle.
  - Product is negated if sign_a XOR sign_b.
  - Quotient is negated if sign_a XOR sign_b.
  - Remainder takes the sign of the dividend.
  - Results and flags are written to the output registers here.
- DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted in that cycle (back-to-back issue allowed).
- busy=1 in CALC and FIX only.
- Latency: start sampled at edge t, done high in the cycle after edge t+WIDTH+1. That is WIDTH+2 cycles, or 34 for WIDTH=32.
- Outputs hold their values until the next FIX or reset. A flush or a new start does not disturb them.
- Flags:
  - N = msb of result_hi for UMULL/SMULL, otherwise msb of result_lo.
  - Z = 1 iff the whole result is zero (both halves for long ops, result_lo only otherwise).
- Divide by zero: result_lo=0, result_hi=a. The full WIDTH+2 latency still applies, with no early exit.
- SDIV of the most-negative value by -1: result_lo=100..0, result_hi=0. No trap.
- MUL: result_hi is forced to 0.
- Flush in CALC or FIX: next state is IDLE, busy drops the next cycle, no done pulse, outputs unchanged. Flush in IDLE or DONE: an accompanying start is dropped and done is suppressed.
- Reset mid-operation: same as flush, and the outputs are also cleared.

Decomposition:
- Shared package arm_muldiv_pkg:
  - op encoding localparams (OP_MUL, OP_UMULL, OP_SMULL, OP_UDIV, OP_SDIV).
  - state encoding (S_IDLE, S_CALC, S_FIX, S_DONE).
  - helper function is_signed_op.
- One sub-module, muldiv_step. It is purely combinational: it takes the accumulator/remainder, the operand and the mode, and returns the next accumulator/remainder plus the quotient bit. It is instantiated once; the FSM, counter and sign-fix logic stay in arm_muldiv_unit.

Test Plan (WIDTH=32):
- MUL a=7 b=6 -> done exactly 34 cycles after start; lo=42, hi=0, flags N=0 Z=0; busy high for 33 cycles.
- SMULL a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, N=1, Z=0. UMULL a=0xFFFFFFFF b=2 -> hi=1, lo=0xFFFFFFFE.
- UDIV a=100 b=7 -> lo=14, hi=2. SDIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Corner divides:
  - UDIV a=5 b=0 -> lo=0, hi=5, latency 34.
  - SDIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, N=1.
  - UMULL a=0 b=x -> Z=1.
- Flush and ignored starts:
  - Flush 10 cycles into an operation -> busy=0 on the next cycle, no done, outputs keep the previous result.
  - start pulsed while busy (different operands) -> ignored; the original result is unaffected.
- Back-to-back issue and reset:
  - start asserted in the DONE cycle -> second done exactly 34 cycles later.
  - reset at cycle 5 of an operation -> all outputs 0 next cycle, unit in IDLE.

Source files
------------

// File: rtl/arm_muldiv_pkg.sv
// Shared encodings and op-class helpers for the iterative multiply/divide unit.
package arm_muldiv_pkg;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_UMULL = 3'd1;
  localparam logic [2:0] OP_SMULL = 3'd2;
  localparam logic [2:0] OP_UDIV  = 3'd3;
  localparam logic [2:0] OP_SDIV  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_SMULL) || (op == OP_SDIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_UDIV) || (op == OP_SDIV);
  endfunction

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_UMULL) || (op == OP_SMULL);
  endfunction

  function automatic logic is_valid_op(input logic [2:0] op);
    return op <= OP_SDIV;
  endfunction

endpackage

// File: rtl/arm_muldiv_unit_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               div_mode_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               q_bit_o
);
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned DW = WIDTH + 2;

  logic [SW-1:0] sum;
  logic [SW-1:0] rem_sh;
  logic [DW-1:0] diff;

  // Multiply keeps the multiplier in the low half and shifts the partial sum in from the top.
  // Divide keeps {remainder, dividend}; the quotient bit fills the vacated lsb in the caller.
  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : SW'(0));
    rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff    = {1'b0, rem_sh} - {2'b00, operand_i};
    q_bit_o = 1'b0;
    if (div_mode_i) begin
      q_bit_o = ~diff[DW-1];
      acc_o   = {(diff[DW-1] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o   = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/arm_muldiv_unit.sv
// Iterative MUL/UMULL/SMULL/UDIV/SDIV unit for the EX stage with start/busy/done handshake.
module arm_muldiv_unit
  import arm_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] a_q;
  logic [2:0]       op_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic             b_zero_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [1:0]       flags_q;

  logic             sign_a_c;
  logic             sign_b_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [ACC_W-1:0] step_acc;
  logic             step_q;
  logic [ACC_W-1:0] prod_c;
  logic [WIDTH-1:0] quo_c;
  logic [WIDTH-1:0] rem_c;
  logic [WIDTH-1:0] fix_lo_c;
  logic [WIDTH-1:0] fix_hi_c;
  logic [1:0]       fix_flags_c;

  // Operands are iterated as magnitudes; signs are reapplied in FIX.
  always_comb begin
    sign_a_c = is_signed_op(op) && a[WIDTH-1];
    sign_b_c = is_signed_op(op) && b[WIDTH-1];
    mag_a_c  = sign_a_c ? (WIDTH'(0) - a) : a;
    mag_b_c  = sign_b_c ? (WIDTH'(0) - b) : b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i      (acc_q),
    .operand_i  (opnd_q),
    .div_mode_i (is_div_op(op_q)),
    .acc_o      (step_acc),
    .q_bit_o    (step_q)
  );

  assign acc_d = is_div_op(op_q) ? {step_acc[ACC_W-1:1], step_q} : step_acc;

  // Sign correction and result/flag selection for the FIX cycle.
  always_comb begin
    prod_c   = (sign_a_q ^ sign_b_q) ? (ACC_W'(0) - acc_q) : acc_q;
    quo_c    = (sign_a_q ^ sign_b_q) ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem_c    = sign_a_q ? (WIDTH'(0) - acc_q[ACC_W-1:WIDTH]) : acc_q[ACC_W-1:WIDTH];
    fix_lo_c = prod_c[WIDTH-1:0];
    fix_hi_c = (op_q == OP_MUL) ? WIDTH'(0) : prod_c[ACC_W-1:WIDTH];
    if (is_div_op(op_q)) begin
      fix_lo_c = b_zero_q ? WIDTH'(0) : quo_c;
      fix_hi_c = b_zero_q ? a_q : rem_c;
    end
    fix_flags_c[1] = is_long_op(op_q) ? fix_hi_c[WIDTH-1] : fix_lo_c[WIDTH-1];
    fix_flags_c[0] = (fix_lo_c == WIDTH'(0)) && (!is_long_op(op_q) || (fix_hi_c == WIDTH'(0)));
  end

  // Control FSM and all registered state; reset beats flush beats start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      op_q     <= OP_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (start && is_valid_op(op)) begin
            state_q  <= S_CALC;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_W'(WIDTH - 1);
            op_q     <= op;
            a_q      <= a;
            sign_a_q <= sign_a_c;
            sign_b_q <= sign_b_c;
            b_zero_q <= (b == WIDTH'(0));
            acc_q    <= is_div_op(op) ? {WIDTH'(0), mag_a_c} : {WIDTH'(0), mag_b_c};
            opnd_q   <= is_div_op(op) ? mag_b_c : mag_a_c;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(0)) state_q <= S_FIX;
        end
        S_FIX: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          lo_q    <= fix_lo_c;
          hi_q    <= fix_hi_c;
          flags_q <= fix_flags_c;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_arm_muldiv_unit.sv
// Self-checking bench: arithmetic reference model with latency tracking, directed corners plus random ops.
module tb_arm_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          flush = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result_lo;
  logic [W-1:0]  result_hi;
  logic [1:0]    flags;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  arm_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of each op, computed with plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] lo, output logic [W-1:0] hi,
                                 output logic [1:0] fl);
    logic [63:0] p;
    longint      lx, ly;
    int          sx, sy;
    logic        long_op;
    sx = x; sy = y;
    lx = longint'(sx); ly = longint'(sy);
    lo = '0; hi = '0;
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; lo = p[31:0]; hi = '0; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; lo = p[31:0]; hi = p[63:32]; end
      3'd2: begin p = lx * ly; lo = p[31:0]; hi = p[63:32]; end
      3'd3: begin
        if (y == 0) begin lo = '0; hi = x; end
        else begin lo = x / y; hi = x % y; end
      end
      default: begin
        if (y == 0) begin lo = '0; hi = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin lo = x; hi = '0; end
        else begin lo = sx / sy; hi = sx % sy; end
      end
    endcase
    long_op = (o == 3'd1) || (o == 3'd2);
    fl[1] = long_op ? hi[31] : lo[31];
    fl[0] = long_op ? ({hi, lo} == 64'd0) : (lo == '0);
  endfunction

  // Cycle-level expectation: accepted op completes WIDTH+1 edges after the sampling edge.
  int           left = 0;
  logic         exp_busy = 1'b0, exp_done = 1'b0;
  logic [W-1:0] exp_lo = '0, exp_hi = '0, pend_lo = '0, pend_hi = '0;
  logic [1:0]   exp_fl = '0, pend_fl = '0;

  always @(posedge clk) begin
    if (reset) begin
      left = 0; exp_done = 1'b0; exp_lo = '0; exp_hi = '0; exp_fl = '0;
    end else begin
      exp_done = 1'b0;
      if (left > 0) begin
        if (flush) left = 0;
        else begin
          left--;
          if (left == 0) begin
            exp_done = 1'b1; exp_lo = pend_lo; exp_hi = pend_hi; exp_fl = pend_fl;
          end
        end
      end else if (!flush && start && op <= 3'd4) begin
        left = W + 1;
        ref_op(op, a, b, pend_lo, pend_hi, pend_fl);
      end
    end
    exp_busy = (left > 0);
  end

  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(exp_busy));
    check("done", 64'(done), 64'(exp_done));
    check("result_lo", 64'(result_lo), 64'(exp_lo));
    check("result_hi", 64'(result_hi), 64'(exp_hi));
    check("flags", 64'(flags), 64'(exp_fl));
  end

  // Issue one op at the current time (just after an edge) and wait for done.
  task automatic run(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     output int lat, output int nbusy);
    start = 1'b1; op = o; a = x; b = y;
    lat = 0; nbusy = 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (busy) nbusy++;
      if (done) break;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: op %0d no done within %0d cycles", o, lat);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    if (busy) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  typedef struct {
    logic [2:0]   o;
    logic [W-1:0] x, y, lo, hi;
    logic [1:0]   fl;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, nb, k, seen;
    logic [W-1:0] mlo, mhi, x, y;
    logic [1:0] mfl;
    logic [2:0] o;

    vecs[0] = '{3'd0, 32'd7,          32'd6,          32'd42,         32'd0,          2'b00};
    vecs[1] = '{3'd2, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  32'hFFFF_FFFF,  2'b10};
    vecs[2] = '{3'd1, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32'd1,          2'b00};
    vecs[3] = '{3'd3, 32'd100,        32'd7,          32'd14,         32'd2,          2'b00};
    vecs[4] = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  2'b10};
    vecs[5] = '{3'd3, 32'd5,          32'd0,          32'd0,          32'd5,          2'b01};
    vecs[6] = '{3'd1, 32'd0,          32'h1234_5678,  32'd0,          32'd0,          2'b01};
    vecs[7] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          2'b10};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_lo", 64'(result_lo), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);

    // Pin the model against hand-computed values.
    foreach (vecs[i]) begin
      ref_op(vecs[i].o, vecs[i].x, vecs[i].y, mlo, mhi, mfl);
      check("model_lo", 64'(mlo), 64'(vecs[i].lo));
      check("model_hi", 64'(mhi), 64'(vecs[i].hi));
      check("model_flags", 64'(mfl), 64'(vecs[i].fl));
    end

    // Directed ops, issued back-to-back from each DONE cycle.
    foreach (vecs[i]) begin
      run(vecs[i].o, vecs[i].x, vecs[i].y, lat, nb);
      check("dir_latency", 64'(lat), 64'(W + 2));
      check("dir_busy_cycles", 64'(nb), 64'(W + 1));
      check("dir_lo", 64'(result_lo), 64'(vecs[i].lo));
      check("dir_hi", 64'(result_hi), 64'(vecs[i].hi));
      check("dir_flags", 64'(flags), 64'(vecs[i].fl));
    end

    // Flush ten cycles in: no done, previous result retained.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_keep_lo", 64'(result_lo), 64'h8000_0000);

    // A start while busy is dropped.
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (!done && k < 100) begin @(posedge clk); #1; k++; end
    check("busy_start_lo", 64'(result_lo), 64'd14);
    check("busy_start_hi", 64'(result_hi), 64'd2);
    @(posedge clk); #1;
    check("busy_start_idle", 64'(busy), 64'd0);

    // Reset at cycle 5 of an operation.
    start = 1'b1; op = 3'd2; a = 32'hFFFF_FFFD; b = 32'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("rst_lo", 64'(result_lo), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    check("rst_no_done", 64'(seen), 64'd0);

    // Random ops with occasional flushes and reserved encodings.
    for (int it = 0; it < 150; it++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: begin x = 32'($urandom_range(0, 300)); y = 32'($urandom_range(0, 20)); end
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        3: y = -(32'($urandom_range(1, 9)));
        default: ;
      endcase
      if (o > 3'd4) begin
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1 start = 1'b0;
        check("reserved_ignored", 64'(busy), 64'd0);
      end else if ($urandom_range(0, 7) == 0) begin
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1 start = 1'b0;
        k = $urandom_range(0, 34);
        repeat (k) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_idle();
      end else begin
        run(o, x, y, lat, nb);
        check("rand_latency", 64'(lat), 64'(W + 2));
      end
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
